// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store.
// Holds each returned word until the owning pipeline register consumes it.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        stallreq_if,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stallreq_mem,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic if_done;
    logic mem_done;
    logic if_discard;

    logic start_mem;
    logic start_if;
    logic ack_mem;
    logic ack_if;
    logic if_keep;

    assign stallreq_if  = if_ce & ~if_done;
    assign stallreq_mem = mem_ce & ~mem_done;
    assign bus_stb      = bus_cyc;

    // A fetch word is only kept if no flush hit it while in flight.
    assign if_keep = ack_if & ~if_discard & ~flush;

    always_comb begin
        state_d   = state_q;
        start_mem = 1'b0;
        start_if  = 1'b0;
        ack_mem   = 1'b0;
        ack_if    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_ce && !mem_done) begin
                    state_d   = MEM_ACC;
                    start_mem = 1'b1;
                end else if (if_ce && !if_done) begin
                    state_d  = IF_ACC;
                    start_if = 1'b1;
                end
            end
            MEM_ACC: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    ack_mem = 1'b1;
                end
            end
            IF_ACC: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    ack_if  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_sel    <= 4'h0;
            bus_wdata  <= 32'h0;
            if_rdata   <= 32'h0;
            mem_rdata  <= 32'h0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            if_discard <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_mem) begin
                bus_cyc   <= 1'b1;
                bus_we    <= mem_we;
                bus_addr  <= mem_addr;
                bus_sel   <= mem_sel;
                bus_wdata <= mem_wdata;
            end else if (start_if) begin
                bus_cyc   <= 1'b1;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_sel   <= 4'b1111;
                bus_wdata <= 32'h0;
            end else if (ack_mem || ack_if) begin
                bus_cyc <= 1'b0;
            end

            if (ack_mem) begin
                mem_rdata <= bus_rdata;
            end
            if (if_keep) begin
                if_rdata <= bus_rdata;
            end

            if (ack_mem) begin
                mem_done <= 1'b1;
            end else if (mem_done && !stall[4]) begin
                mem_done <= 1'b0;
            end

            if (if_keep) begin
                if_done <= 1'b1;
            end else if (if_done && (!stall[1] || flush)) begin
                if_done <= 1'b0;
            end

            // The bus cycle is never aborted; a flushed fetch is just dropped on ack.
            if (ack_if) begin
                if_discard <= 1'b0;
            end else if (state_q == IF_ACC && flush) begin
                if_discard <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus
// hand-written store, hold, flush and reset sequences.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stallreq_if;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_mem;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .if_ce        (if_ce),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .stallreq_if  (stallreq_if),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_sel      (mem_sel),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stallreq_mem (stallreq_mem),
        .bus_cyc      (bus_cyc),
        .bus_stb      (bus_stb),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        if_ce;
        logic [31:0] if_addr;
        logic        mem_ce;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [3:0]  mem_sel;
        logic [31:0] mem_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_cyc;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        logic        e_sif;
        logic        e_smem;
        logic [31:0] e_ird;
        logic [31:0] e_mrd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic bus_chk(input string tag, input logic c, input logic w,
                           input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
        chk({tag, ".cyc"}, 32'(bus_cyc), 32'(c));
        chk({tag, ".stb"}, 32'(bus_stb), 32'(c));
        if (c) begin
            chk({tag, ".we"}, 32'(bus_we), 32'(w));
            chk({tag, ".addr"}, bus_addr, a);
            chk({tag, ".sel"}, 32'(bus_sel), 32'(s));
            chk({tag, ".wdata"}, bus_wdata, d);
        end
    endtask

    task automatic idle_in();
        stall     = 6'h0;
        flush     = 1'b0;
        if_ce     = 1'b0;
        if_addr   = 32'h0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_sel   = 4'h0;
        mem_wdata = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fetch only, then MEM/IF contention, then a stray ack in IDLE
        vecs[0]  = '{6'h00, 0, 0, 32'h0,  0, 0, 32'h0,   4'h0, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h0, 32'h0};
        vecs[1]  = '{6'h1F, 0, 1, 32'h10, 0, 0, 32'h0,   4'h0, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 32'h0, 32'h0};
        vecs[2]  = '{6'h1F, 0, 1, 32'h10, 0, 0, 32'h0,   4'h0, 32'h0, 1, 32'h3C010101,
                     1, 0, 32'h10,  4'hF, 32'h0, 1, 0, 32'h0, 32'h0};
        vecs[3]  = '{6'h00, 0, 1, 32'h10, 0, 0, 32'h0,   4'h0, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h3C010101, 32'h0};
        vecs[4]  = '{6'h00, 0, 0, 32'h0,  0, 0, 32'h0,   4'h0, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h3C010101, 32'h0};
        vecs[5]  = '{6'h1F, 0, 1, 32'h10, 1, 0, 32'h100, 4'hF, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 1, 1, 32'h3C010101, 32'h0};
        vecs[6]  = '{6'h1F, 0, 1, 32'h10, 1, 0, 32'h100, 4'hF, 32'h0, 1, 32'hCAFE0001,
                     1, 0, 32'h100, 4'hF, 32'h0, 1, 1, 32'h3C010101, 32'h0};
        vecs[7]  = '{6'h1F, 0, 1, 32'h10, 1, 0, 32'h100, 4'hF, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 1, 0, 32'h3C010101, 32'hCAFE0001};
        vecs[8]  = '{6'h1F, 0, 1, 32'h10, 1, 0, 32'h100, 4'hF, 32'h0, 1, 32'h24020005,
                     1, 0, 32'h10,  4'hF, 32'h0, 1, 0, 32'h3C010101, 32'hCAFE0001};
        vecs[9]  = '{6'h00, 0, 1, 32'h10, 1, 0, 32'h100, 4'hF, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h24020005, 32'hCAFE0001};
        vecs[10] = '{6'h00, 0, 0, 32'h0,  0, 0, 32'h0,   4'h0, 32'h0, 1, 32'hFFFFFFFF,
                     0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h24020005, 32'hCAFE0001};
        vecs[11] = '{6'h00, 0, 0, 32'h0,  0, 0, 32'h0,   4'h0, 32'h0, 0, 32'h0,
                     0, 0, 32'h0,   4'h0, 32'h0, 0, 0, 32'h24020005, 32'hCAFE0001};

        idle_in();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
        settle();
        bus_chk("rst", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("rst.we", 32'(bus_we), 32'h0);
        chk("rst.addr", bus_addr, 32'h0);
        chk("rst.sel", 32'(bus_sel), 32'h0);
        chk("rst.wdata", bus_wdata, 32'h0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.mem_rdata", mem_rdata, 32'h0);
        adv();

        for (int i = 0; i < 12; i++) begin
            stall     = vecs[i].stall;
            flush     = vecs[i].flush;
            if_ce     = vecs[i].if_ce;
            if_addr   = vecs[i].if_addr;
            mem_ce    = vecs[i].mem_ce;
            mem_we    = vecs[i].mem_we;
            mem_addr  = vecs[i].mem_addr;
            mem_sel   = vecs[i].mem_sel;
            mem_wdata = vecs[i].mem_wdata;
            bus_ack   = vecs[i].ack;
            bus_rdata = vecs[i].rdata;
            settle();
            bus_chk($sformatf("v%0d", i), vecs[i].e_cyc, vecs[i].e_we,
                    vecs[i].e_addr, vecs[i].e_sel, vecs[i].e_wdata);
            chk($sformatf("v%0d.sreq_if", i), 32'(stallreq_if), 32'(vecs[i].e_sif));
            chk($sformatf("v%0d.sreq_mem", i), 32'(stallreq_mem), 32'(vecs[i].e_smem));
            chk($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].e_ird);
            chk($sformatf("v%0d.mem_rdata", i), mem_rdata, vecs[i].e_mrd);
            adv();
        end

        // store, slave inserts 3 wait states
        idle_in();
        stall = 6'h1F; mem_ce = 1; mem_we = 1;
        mem_addr = 32'h200; mem_sel = 4'b0011; mem_wdata = 32'h0000ABCD;
        settle();
        bus_chk("st_req", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("st_req.sreq_mem", 32'(stallreq_mem), 32'h1);
        adv();
        for (int i = 0; i < 4; i++) begin
            mem_addr = 32'h204; mem_wdata = 32'h11111111;
            bus_ack = (i == 3);
            settle();
            bus_chk($sformatf("st_w%0d", i), 1, 1, 32'h200, 4'b0011, 32'h0000ABCD);
            chk($sformatf("st_w%0d.sreq_mem", i), 32'(stallreq_mem), 32'h1);
            adv();
        end
        bus_ack = 0;
        settle();
        bus_chk("st_done", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("st_done.sreq_mem", 32'(stallreq_mem), 32'h0);
        adv();
        stall = 6'h0;
        settle();
        bus_chk("st_cons", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("st_cons.sreq_mem", 32'(stallreq_mem), 32'h0);
        adv();
        mem_ce = 0;
        settle();
        bus_chk("st_idle", 0, 0, 32'h0, 4'h0, 32'h0);
        adv();

        // load completes while MEM/WB is held; IF uses the bus meanwhile
        idle_in();
        stall = 6'h1F; mem_ce = 1; mem_addr = 32'h300; mem_sel = 4'hF;
        if_ce = 1; if_addr = 32'h20;
        settle();
        chk("h0.sreq_mem", 32'(stallreq_mem), 32'h1);
        bus_chk("h0", 0, 0, 32'h0, 4'h0, 32'h0);
        adv();
        bus_ack = 1; bus_rdata = 32'h12345678;
        settle();
        bus_chk("h1", 1, 0, 32'h300, 4'hF, 32'h0);
        adv();
        bus_ack = 0; bus_rdata = 32'h0;
        settle();
        bus_chk("h2", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("h2.mem_rdata", mem_rdata, 32'h12345678);
        chk("h2.sreq_mem", 32'(stallreq_mem), 32'h0);
        chk("h2.sreq_if", 32'(stallreq_if), 32'h1);
        adv();
        bus_ack = 1; bus_rdata = 32'h00000013;
        settle();
        bus_chk("h3", 1, 0, 32'h20, 4'hF, 32'h0);
        chk("h3.mem_rdata", mem_rdata, 32'h12345678);
        adv();
        bus_ack = 0; bus_rdata = 32'h0;
        settle();
        bus_chk("h4", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("h4.sreq_if", 32'(stallreq_if), 32'h0);
        chk("h4.sreq_mem", 32'(stallreq_mem), 32'h0);
        chk("h4.mem_rdata", mem_rdata, 32'h12345678);
        chk("h4.if_rdata", if_rdata, 32'h00000013);
        adv();
        stall = 6'h0;
        settle();
        bus_chk("h5", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("h5.sreq_mem", 32'(stallreq_mem), 32'h0);
        adv();
        stall = 6'h1F; if_ce = 0; mem_addr = 32'h304;
        settle();
        chk("h6.sreq_mem", 32'(stallreq_mem), 32'h1);
        bus_chk("h6", 0, 0, 32'h0, 4'h0, 32'h0);
        adv();
        bus_ack = 1; bus_rdata = 32'hAAAA5555;
        settle();
        bus_chk("h7", 1, 0, 32'h304, 4'hF, 32'h0);
        adv();
        idle_in();
        settle();
        bus_chk("h8", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("h8.mem_rdata", mem_rdata, 32'hAAAA5555);
        adv();

        // flush while a fetch waits; the late word must be dropped
        idle_in();
        stall = 6'h1F; if_ce = 1; if_addr = 32'h40;
        settle();
        chk("f0.sreq_if", 32'(stallreq_if), 32'h1);
        adv();
        flush = 1;
        settle();
        bus_chk("f1", 1, 0, 32'h40, 4'hF, 32'h0);
        adv();
        flush = 0; if_addr = 32'h80;
        settle();
        bus_chk("f2", 1, 0, 32'h40, 4'hF, 32'h0);
        adv();
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        settle();
        bus_chk("f3", 1, 0, 32'h40, 4'hF, 32'h0);
        adv();
        bus_ack = 0; bus_rdata = 32'h0;
        settle();
        bus_chk("f4", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("f4.if_rdata", if_rdata, 32'h00000013);
        chk("f4.sreq_if", 32'(stallreq_if), 32'h1);
        adv();
        bus_ack = 1; bus_rdata = 32'h00000093;
        settle();
        bus_chk("f5", 1, 0, 32'h80, 4'hF, 32'h0);
        adv();
        bus_ack = 0; bus_rdata = 32'h0; stall = 6'h0;
        settle();
        chk("f6.if_rdata", if_rdata, 32'h00000093);
        chk("f6.sreq_if", 32'(stallreq_if), 32'h0);
        adv();
        if_ce = 0;
        settle();
        bus_chk("f7", 0, 0, 32'h0, 4'h0, 32'h0);
        adv();

        // ack and flush on the same edge
        idle_in();
        stall = 6'h1F; if_ce = 1; if_addr = 32'h50;
        adv();
        bus_ack = 1; flush = 1; bus_rdata = 32'hBADBAD00;
        settle();
        bus_chk("g1", 1, 0, 32'h50, 4'hF, 32'h0);
        adv();
        bus_ack = 0; flush = 0; bus_rdata = 32'h0;
        settle();
        bus_chk("g2", 0, 0, 32'h0, 4'h0, 32'h0);
        chk("g2.if_rdata", if_rdata, 32'h00000093);
        chk("g2.sreq_if", 32'(stallreq_if), 32'h1);
        adv();
        bus_ack = 1; bus_rdata = 32'h11112222;
        settle();
        bus_chk("g3", 1, 0, 32'h50, 4'hF, 32'h0);
        adv();
        bus_ack = 0; bus_rdata = 32'h0; stall = 6'h0;
        settle();
        chk("g4.if_rdata", if_rdata, 32'h11112222);
        chk("g4.sreq_if", 32'(stallreq_if), 32'h0);
        adv();
        if_ce = 0;
        adv();

        // reset during a wait-state store; the late ack is ignored
        idle_in();
        stall = 6'h1F; mem_ce = 1; mem_we = 1; mem_addr = 32'h400;
        mem_sel = 4'hF; mem_wdata = 32'h55AA55AA;
        adv();
        rst = 1;
        settle();
        bus_chk("r1", 1, 1, 32'h400, 4'hF, 32'h55AA55AA);
        adv();
        rst = 0; mem_ce = 0; mem_we = 0; stall = 6'h0;
        bus_ack = 1; bus_rdata = 32'h77777777;
        settle();
        chk("r2.cyc", 32'(bus_cyc), 32'h0);
        chk("r2.stb", 32'(bus_stb), 32'h0);
        chk("r2.we", 32'(bus_we), 32'h0);
        chk("r2.addr", bus_addr, 32'h0);
        chk("r2.sel", 32'(bus_sel), 32'h0);
        chk("r2.wdata", bus_wdata, 32'h0);
        chk("r2.if_rdata", if_rdata, 32'h0);
        chk("r2.mem_rdata", mem_rdata, 32'h0);
        adv();
        bus_ack = 0; bus_rdata = 32'h0;
        settle();
        chk("r3.mem_rdata", mem_rdata, 32'h0);
        chk("r3.if_rdata", if_rdata, 32'h0);
        bus_chk("r3", 0, 0, 32'h0, 4'h0, 32'h0);
        adv();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
